// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider
// and the ALU function codes it drives.
package div_pkg;

    localparam int DW      = 32;
    localparam int FUNCT_W = 6;

    localparam logic [5:0] FUNCT_NOP = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_SUB = 6'b001010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_ctrl.sv
// Restoring unsigned divider sequencer; one quotient bit per cycle,
// trial subtraction done by the shared ALU through the alu_* ports.
module divider_ctrl #(
    parameter int DW      = div_pkg::DW,
    parameter int FUNCT_W = div_pkg::FUNCT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DW-1:0]      dividend,
    input  logic [DW-1:0]      divisor,
    output logic [DW-1:0]      alu_src1,
    output logic [DW-1:0]      alu_src2,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DW-1:0]      alu_result,
    input  logic               alu_carry,
    output logic               busy,
    output logic               ready,
    output logic [DW-1:0]      quotient,
    output logic [DW-1:0]      remainder,
    output logic               div_by_zero
);

    import div_pkg::*;

    localparam int          CW   = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_t      r_state;
    div_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_work;
    logic [DW-1:0]   r_div;
    logic [DW-1:0]   r_quot;
    logic [DW-1:0]   r_rem;
    logic            r_dbz;

    logic [2*DW-1:0] w_shift;
    logic [2*DW-1:0] w_work_nxt;
    logic            w_run;
    logic            w_zero_div;

    assign w_run      = (r_state == ST_RUN);
    assign w_zero_div = (divisor == '0);
    assign w_shift    = r_work << 1;

    // No borrow means the shifted remainder covers the divisor:
    // keep the difference and shift in a 1.
    always_comb begin
        w_work_nxt = w_shift;
        if (!alu_carry) begin
            w_work_nxt = {alu_result, w_shift[DW-1:1], 1'b1};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_div ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_src1  = '0;
        alu_src2  = '0;
        alu_funct = FUNCT_W'(FUNCT_NOP);
        if (w_run) begin
            alu_src1  = w_shift[2*DW-1:DW];
            alu_src2  = r_div;
            alu_funct = FUNCT_W'(FUNCT_SUB);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_div   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dbz <= w_zero_div;
                        if (w_zero_div) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                        end else begin
                            r_div  <= divisor;
                            r_work <= {{DW{1'b0}}, dividend};
                            r_cnt  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_quot <= w_work_nxt[DW-1:0];
                        r_rem  <= w_work_nxt[2*DW-1:DW];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = w_run;
    assign ready       = (r_state == ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl with a behavioural subtract-only ALU.
// Inputs change and outputs are sampled on the falling edge.
module tb_divider_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [DW-1:0] alu_src1;
    logic [DW-1:0] alu_src2;
    logic [5:0]    alu_funct;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          busy;
    logic          ready;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign alu_result = (alu_funct == 6'b001010) ? alu_src1 - alu_src2 : '0;
    assign alu_carry  = (alu_funct == 6'b001010) ? (alu_src1 < alu_src2) : 1'b0;

    divider_ctrl #(.DW(DW), .FUNCT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge with the DUT in IDLE; returns on the
    // falling edge just after the ready pulse (DUT back in IDLE).
    // inj_cyc > 0 raises a second start 9/3 during that cycle.
    task automatic do_div(input string tag, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int exp_lat,
                          input logic [DW-1:0] exp_q,
                          input logic [DW-1:0] exp_r,
                          input logic exp_dbz, input int inj_cyc);
        int  lat;
        bit  seen;
        bit  funct_nz;
        lat      = 0;
        seen     = 1'b0;
        funct_nz = 1'b0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int c = 1; c <= 45 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                if (!exp_dbz) begin
                    check({tag, " busy"}, 64'(busy), 64'd1);
                    check({tag, " funct"}, 64'(alu_funct), 64'h0a);
                    check({tag, " src2"}, 64'(alu_src2), 64'(b));
                end
            end
            if (inj_cyc > 0 && c == inj_cyc) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (inj_cyc > 0 && c == inj_cyc + 1) start = 1'b0;
            if (alu_funct != 6'b0) funct_nz = 1'b1;
            if (ready) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " quot"}, 64'(quotient), 64'(exp_q));
        check({tag, " rem"}, 64'(remainder), 64'(exp_r));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        if (exp_dbz) check({tag, " nop"}, 64'(funct_nz), 64'd0);
        @(negedge clk);
        check({tag, " pulse"}, 64'(ready), 64'd0);
    endtask

    // Start 100/7 and pull rst_n low during cycle 15.
    task automatic do_abort();
        bit any_ready;
        any_ready = 1'b0;
        start     = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (ready) any_ready = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort quot", 64'(quotient), 64'd0);
        check("abort rem", 64'(remainder), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort dbz", 64'(div_by_zero), 64'd0);
        check("abort src1", 64'(alu_src1), 64'd0);
        check("abort funct", 64'(alu_funct), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (ready) any_ready = 1'b1;
            @(negedge clk);
        end
        check("abort noready", 64'(any_ready), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst ready", 64'(ready), 64'd0);
        check("rst quot", 64'(quotient), 64'd0);
        check("rst rem", 64'(remainder), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        check("rst funct", 64'(alu_funct), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div("100/7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);
        do_div("3/10", 32'd3, 32'd10, 33, 32'd0, 32'd3, 1'b0, 0);
        do_div("max/1", 32'hFFFF_FFFF, 32'd1, 33,
               32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        do_div("5/0", 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        do_div("0/9", 32'd0, 32'd9, 33, 32'd0, 32'd0, 1'b0, 0);
        do_div("max/max-1", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33,
               32'd1, 32'd1, 1'b0, 0);
        do_div("ignore", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 10);
        do_abort();
        do_div("20/6", 32'd20, 32'd6, 33, 32'd3, 32'd2, 1'b0, 0);
        do_div("b2b", 32'h8000_0000, 32'h10, 33,
               32'h0800_0000, 32'd0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/divider_ctrl.md
DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 Parameters: DW, default 32, operand width; FUNCT_W, default 6, ALU function-code width.
REQ-002 clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  DW  unsigned dividend; sampled with start.
REQ-006 divisor  input  DW  unsigned divisor; sampled with start.
REQ-007 alu_src1  output  DW  ALU operand 1: working remainder after shift.
REQ-008 alu_src2  output  DW  ALU operand 2: latched divisor.
REQ-009 alu_funct  output  FUNCT_W  ALU function code.
REQ-010 alu_result  input  DW  ALU result, combinational.
REQ-011 alu_carry  input  1  ALU borrow out; 1 means src1 < src2 on subtract.
REQ-012 busy  output  1  high in RUN.
REQ-013 ready  output  1  one-cycle pulse in DONE.
REQ-014 quotient  output  DW  result quotient; held until the next accepted start.
REQ-015 remainder  output  DW  result remainder; held until the next accepted start.
REQ-016 div_by_zero  output  1  high with ready when divisor was 0; held with the results.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE, start=1, divisor!=0: latch divisor; load 2*DW-bit work register {R,Q}={0,dividend}; clear iteration counter; go to RUN.
REQ-019 IDLE, start=1, divisor=0: go to DONE next cycle with quotient=all-ones, remainder=dividend, div_by_zero=1; ALU not used.
REQ-020 RUN, each cycle one restoring iteration: alu_src1 = upper DW bits of ({R,Q}<<1), alu_src2 = divisor, alu_funct = 6'b001010 (subtract).
REQ-021 alu_carry=0: R <= alu_result, Q <= {Q[DW-2:0],1}.
REQ-022 alu_carry=1: {R,Q} <= {R,Q}<<1, with new Q LSB=0.
REQ-023 RUN SHALL last exactly DW cycles, counter 0..DW-1; at counter DW-1 go to DONE.
REQ-024 Latency: start accepted in cycle 0; ready=1 in cycle DW+1, i.e. 33 for DW=32; divide-by-zero ready=1 in cycle 1.
REQ-025 DONE SHALL last one cycle, assert ready, copy Q/R to quotient/remainder in the same edge as entry, then return to IDLE.
REQ-026 start during RUN or DONE SHALL be ignored; no queuing.
REQ-027 Outside RUN: alu_funct=6'b000000 (ALU no-op), alu_src1=0, alu_src2=0.
REQ-028 Arithmetic SHALL be unsigned throughout, with no overflow case; 0/x gives Q=0, R=0.
REQ-029 div_by_zero SHALL clear on the next accepted start.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE and zero the counter, work register, latched divisor, quotient, remainder, ready, busy and div_by_zero, including mid-RUN.
REQ-031 An aborted operation SHALL produce no ready pulse; the first start after reset release is accepted normally.

Structure
REQ-032 Shared package div_pkg SHALL hold DW, FUNCT_W, FUNCT_ADD=6'b001001, FUNCT_SUB=6'b001010, FUNCT_NOP=6'b000000, and the state encoding.
REQ-033 No sub-module inside divider_ctrl; the existing ALU is instantiated beside it in the divider top and wired through the alu_* ports.
REQ-034 The iteration counter SHALL be $clog2(DW)+1 bits wide.

Verification
REQ-035 Start, 100/7 -> ready at cycle 33, quotient=14, remainder=2, div_by_zero=0.
REQ-036 Start, 3/10 -> quotient=0, remainder=3; 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-037 Start, 5/0 -> ready at cycle 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; alu_funct stays 000000.
REQ-038 Start 100/7, then start 9/3 at cycle 10 -> second request ignored; cycle-33 result is 14 r 2.
REQ-039 rst_n=0 at cycle 15 of 100/7 -> all outputs 0 next edge, no ready; then start 20/6 -> quotient=3, remainder=2 at 33 cycles.
REQ-040 Back-to-back: start 0x80000000/0x10 asserted in the cycle after ready -> accepted, quotient=0x08000000, remainder=0.
